// File: rtl/dcache_pkg.sv
// Shared types for the data-cache line port: line/beat geometry and FSM states.
package dcache_pkg;
   localparam int LINE_BYTES = 64;
   localparam int BEAT_BITS  = 64;
   localparam int BEATS      = LINE_BYTES * 8 / BEAT_BITS;

   typedef logic [LINE_BYTES*8-1:0] line_t;
   typedef logic [BEAT_BITS-1:0]    beat_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR_BEAT,
      WR_ACK
   } state_t;
endpackage

// File: rtl/dcache_line_port.sv
// Memory-side responder: turns one 512-bit cache line read/write into eight
// 64-bit beats on the memory bus and pulses ddone when the line completes.
module dcache_line_port
   import dcache_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        drequest,
   input  logic        dwrenable,
   input  logic [63:0] daddr,
   input  line_t       dwdata,
   output line_t       drdata,
   output logic        ddone,
   output logic        mreq_valid,
   input  logic        mreq_ready,
   output logic        mreq_write,
   output logic [63:0] mreq_addr,
   output beat_t       mreq_wdata,
   input  logic        mresp_valid,
   input  beat_t       mresp_data,
   output logic        err
);

   state_t      state, state_n;
   logic [2:0]  k, k_n, kp1;
   logic [57:0] base, base_n;
   line_t       line, line_n, drdata_n;
   logic        ddone_n, err_n, mreq_valid_n, mreq_write_n;
   logic [63:0] mreq_addr_n;
   beat_t       mreq_wdata_n;
   logic        accept;
   logic        addr_unused;

   // Offset bits inside the line are discarded on purpose.
   assign addr_unused = ^daddr[5:0];
   assign accept      = mreq_valid & mreq_ready;
   assign kp1         = k + 3'd1;

   always_comb begin
      state_n      = state;
      k_n          = k;
      base_n       = base;
      line_n       = line;
      drdata_n     = drdata;
      ddone_n      = 1'b0;
      err_n        = err;
      mreq_valid_n = mreq_valid;
      mreq_write_n = mreq_write;
      mreq_addr_n  = mreq_addr;
      mreq_wdata_n = mreq_wdata;

      if (drequest && state != IDLE)
         err_n = 1'b1;
      // A response is only legal while data or the write ack is expected.
      if (mresp_valid && (state == IDLE || state == RD_CMD || state == WR_BEAT))
         err_n = 1'b1;

      case (state)
         IDLE: begin
            if (drequest) begin
               base_n       = daddr[63:6];
               k_n          = 3'd0;
               mreq_valid_n = 1'b1;
               mreq_write_n = dwrenable;
               mreq_addr_n  = {daddr[63:6], 6'b0};
               if (dwrenable) begin
                  line_n       = dwdata;
                  mreq_wdata_n = dwdata[BEAT_BITS-1:0];
                  state_n      = WR_BEAT;
               end else begin
                  state_n      = RD_CMD;
               end
            end
         end
         RD_CMD: begin
            if (accept) begin
               mreq_valid_n = 1'b0;
               state_n      = RD_DATA;
            end
         end
         RD_DATA: begin
            if (mresp_valid) begin
               drdata_n[{k, 6'b0} +: BEAT_BITS] = mresp_data;
               k_n = kp1;
               if (k == 3'd7) begin
                  state_n = IDLE;
                  ddone_n = 1'b1;
               end
            end
         end
         WR_BEAT: begin
            if (accept) begin
               k_n = kp1;
               if (k == 3'd7) begin
                  mreq_valid_n = 1'b0;
                  state_n      = WR_ACK;
               end else begin
                  // Beat offset lives in bits [5:3]; no carry into the line address.
                  mreq_addr_n  = {base, kp1, 3'b0};
                  mreq_wdata_n = line[{kp1, 6'b0} +: BEAT_BITS];
               end
            end
         end
         WR_ACK: begin
            if (mresp_valid) begin
               state_n = IDLE;
               ddone_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         k          <= 3'd0;
         base       <= '0;
         line       <= '0;
         drdata     <= '0;
         ddone      <= 1'b0;
         err        <= 1'b0;
         mreq_valid <= 1'b0;
         mreq_write <= 1'b0;
         mreq_addr  <= '0;
         mreq_wdata <= '0;
      end else begin
         state      <= state_n;
         k          <= k_n;
         base       <= base_n;
         line       <= line_n;
         drdata     <= drdata_n;
         ddone      <= ddone_n;
         err        <= err_n;
         mreq_valid <= mreq_valid_n;
         mreq_write <= mreq_write_n;
         mreq_addr  <= mreq_addr_n;
         mreq_wdata <= mreq_wdata_n;
      end
   end

endmodule
